frame_motion_ctrl: RTL and testbench

Position controller for the on-screen frame (cornice) overlay. It replaces the free-running key logic with a frame-synchronous sequencer. It derives a one-cycle frame tick from `VGA_VS` inside the `VGA_CLK` domain and arbitrates the shared position register between manual key requests and an autonomous bounce engine. It outputs the frame's top-left corner (`posx`, `posy`) to the rectangle renderer and BCD display path.

---
 rtl/frame_motion_ctrl.sv | 148 ++++++++++++++
 tb/tb_frame_motion_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_motion_ctrl.sv
// Frame-synchronous position sequencer: manual keys, autonomous bounce, and a HOLD window that arbitrates between them.
// Outputs are registered and update on the edge after the one-cycle frame tick. There is no backpressure.
module frame_motion_ctrl #(
    parameter int H           = 1280,
    parameter int V           = 1024,
    parameter int LARGHEZZA   = 400,
    parameter int ALTEZZA     = 300,
    parameter int STEP        = 1,
    parameter int AUTO_STEP   = 2,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        VGA_VS,
    input  logic        key_x_n,
    input  logic        key_y_n,
    input  logic        dir_x,
    input  logic        dir_y,
    input  logic        auto_en,
    output logic [10:0] posx,
    output logic [10:0] posy,
    output logic        frame_tick,
    output logic [1:0]  mode
);
    localparam logic [10:0] XMAX  = 11'(H - LARGHEZZA);
    localparam logic [10:0] YMAX  = 11'(V - ALTEZZA);
    localparam logic [10:0] XRST  = 11'((H - LARGHEZZA) / 2);
    localparam logic [10:0] YRST  = 11'((V - ALTEZZA) / 2);
    localparam logic [11:0] MSTEP = 12'(STEP);
    localparam logic [11:0] ASTEP = 12'(AUTO_STEP);
    localparam int          HW    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HLOAD = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {MANUAL = 2'd0, AUTO = 2'd1, HOLD = 2'd2} mode_e;

    function automatic logic [10:0] f_manual(input logic [10:0] pos, input logic dir,
                                             input logic [10:0] max);
        logic [11:0] w_p;
        logic [11:0] w_m;
        w_p = {1'b0, pos};
        w_m = {1'b0, max};
        if (dir)
            return (w_p + MSTEP > w_m) ? 11'd0 : 11'(w_p + MSTEP);
        return (w_p < MSTEP) ? max : 11'(w_p - MSTEP);
    endfunction

    // Result packs {new direction, new position}; direction 1 means +.
    function automatic logic [11:0] f_bounce(input logic [10:0] pos, input logic dir,
                                             input logic [10:0] max);
        logic [11:0] w_p;
        logic [11:0] w_m;
        w_p = {1'b0, pos};
        w_m = {1'b0, max};
        if (dir && (w_p + ASTEP >= w_m))
            return {1'b0, max};
        if (!dir && (w_p <= ASTEP))
            return {1'b1, 11'd0};
        return dir ? {1'b1, 11'(w_p + ASTEP)} : {1'b0, 11'(w_p - ASTEP)};
    endfunction

    logic          r_vs_d;
    logic          r_tick;
    logic          r_kx_s1, r_kx_s2;
    logic          r_ky_s1, r_ky_s2;
    logic [10:0]   r_posx, r_posy;
    logic          r_bx, r_by;
    logic [HW-1:0] r_hcnt;
    mode_e         r_mode;

    logic          w_kx, w_ky, w_any;
    logic [10:0]   w_man_x, w_man_y;
    logic [11:0]   w_bnc_x, w_bnc_y;

    assign w_kx    = ~r_kx_s2;
    assign w_ky    = ~r_ky_s2;
    assign w_any   = w_kx | w_ky;
    assign w_man_x = f_manual(r_posx, dir_x, XMAX);
    assign w_man_y = f_manual(r_posy, dir_y, YMAX);
    assign w_bnc_x = f_bounce(r_posx, r_bx, XMAX);
    assign w_bnc_y = f_bounce(r_posy, r_by, YMAX);

    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
            r_vs_d  <= 1'b0;
            r_tick  <= 1'b0;
            r_kx_s1 <= 1'b1;
            r_kx_s2 <= 1'b1;
            r_ky_s1 <= 1'b1;
            r_ky_s2 <= 1'b1;
            r_posx  <= XRST;
            r_posy  <= YRST;
            r_bx    <= 1'b1;
            r_by    <= 1'b1;
            r_hcnt  <= '0;
            r_mode  <= MANUAL;
        end else begin
            r_vs_d  <= VGA_VS;
            r_tick  <= VGA_VS & ~r_vs_d;
            r_kx_s1 <= key_x_n;
            r_kx_s2 <= r_kx_s1;
            r_ky_s1 <= key_y_n;
            r_ky_s2 <= r_ky_s1;
            if (r_tick) begin
                if (!auto_en) begin
                    r_mode <= MANUAL;
                    if (w_kx) r_posx <= w_man_x;
                    if (w_ky) r_posy <= w_man_y;
                end else begin
                    case (r_mode)
                        MANUAL: begin
                            r_mode <= AUTO;
                            {r_bx, r_posx} <= w_bnc_x;
                            {r_by, r_posy} <= w_bnc_y;
                        end
                        AUTO: begin
                            if (w_any) begin
                                r_mode <= HOLD;
                                r_hcnt <= HLOAD;
                                if (w_kx) r_posx <= w_man_x;
                                if (w_ky) r_posy <= w_man_y;
                            end else begin
                                {r_bx, r_posx} <= w_bnc_x;
                                {r_by, r_posy} <= w_bnc_y;
                            end
                        end
                        HOLD: begin
                            if (w_any) begin
                                r_hcnt <= HLOAD;
                                if (w_kx) r_posx <= w_man_x;
                                if (w_ky) r_posy <= w_man_y;
                            end else if (r_hcnt <= HW'(1)) begin
                                r_mode <= AUTO;
                            end else begin
                                r_hcnt <= r_hcnt - HW'(1);
                            end
                        end
                        default: r_mode <= MANUAL;
                    endcase
                end
            end
        end
    end

    assign posx       = r_posx;
    assign posy       = r_posy;
    assign frame_tick = r_tick;
    assign mode       = r_mode;
endmodule

// File: tb/tb_frame_motion_ctrl.sv
// Scoreboard bench for frame_motion_ctrl: every VS rise pushes the model's next state, the monitor pops it on each frame_tick.
module tb_frame_motion_ctrl;
    localparam int XMAX = 880;
    localparam int YMAX = 724;
    localparam int STEP = 1;
    localparam int AS   = 2;
    localparam int HOLD = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        VGA_VS = 1'b0;
    logic        key_x_n = 1'b1;
    logic        key_y_n = 1'b1;
    logic        dir_x = 1'b1;
    logic        dir_y = 1'b1;
    logic        auto_en = 1'b0;
    logic [10:0] posx, posy;
    logic        frame_tick;
    logic [1:0]  mode;

    frame_motion_ctrl dut (
        .VGA_CLK(clk), .reset(reset), .VGA_VS(VGA_VS),
        .key_x_n(key_x_n), .key_y_n(key_y_n), .dir_x(dir_x), .dir_y(dir_y),
        .auto_en(auto_en), .posx(posx), .posy(posy),
        .frame_tick(frame_tick), .mode(mode)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int md;} exp_t;
    exp_t q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: mode 0/1/2, bounce directions as +1/-1.
    int m_x, m_y, m_mode, m_bx, m_by, m_h;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = (1280 - 400) / 2; m_y = (1024 - 300) / 2;
        m_mode = 0; m_bx = 1; m_by = 1; m_h = 0;
    endtask

    function automatic int man_axis(input int p, input bit d, input int mx);
        if (d) return (p + STEP > mx) ? 0 : p + STEP;
        return (p < STEP) ? mx : p - STEP;
    endfunction

    task automatic bounce_axis(inout int p, inout int d, input int mx);
        p = p + d * AS;
        if (d > 0 && p >= mx) begin p = mx; d = -1; end
        else if (d < 0 && p <= 0) begin p = 0; d = 1; end
    endtask

    task automatic model_tick(input bit ae, input bit kx, input bit ky, input bit dx, input bit dy);
        bit any;
        any = kx | ky;
        if (!ae || (m_mode != 0 && any)) begin
            if (ae && m_mode == 1) m_mode = 2;
            if (!ae) m_mode = 0;
            if (m_mode == 2) m_h = HOLD;
            if (kx) m_x = man_axis(m_x, dx, XMAX);
            if (ky) m_y = man_axis(m_y, dy, YMAX);
        end else if (m_mode == 0 || m_mode == 1) begin
            m_mode = 1;
            bounce_axis(m_x, m_bx, XMAX);
            bounce_axis(m_y, m_by, YMAX);
        end else if (m_h == 1) begin
            m_mode = 1;
        end else begin
            m_h = m_h - 1;
        end
    endtask

    task automatic frame(input bit ae, input bit kx, input bit ky, input bit dx, input bit dy, input int hi);
        auto_en = ae; key_x_n = ~kx; key_y_n = ~ky; dir_x = dx; dir_y = dy;
        repeat (3) @(posedge clk);
        #1 VGA_VS = 1'b1;
        model_tick(ae, kx, ky, dx, dy);
        q.push_back('{x: m_x, y: m_y, md: m_mode});
        repeat (hi) @(posedge clk);
        #1 VGA_VS = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: each tick must match a queued expectation, checked one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_tick", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    @(negedge clk);
                    chk("posx", int'(posx), mon_e.x);
                    chk("posy", int'(posy), mon_e.y);
                    chk("mode", int'(mode), mon_e.md);
                    chk("tick_width", int'(frame_tick), 0);
                end
            end
        end
    end

    initial begin
        int ticks;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_posx", int'(posx), 440);
        chk("rst_posy", int'(posy), 362);
        chk("rst_mode", int'(mode), 0);
        chk("rst_tick", int'(frame_tick), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            frame(0, 1, 0, 1, 0, 1);
            chk("man_step_x", int'(posx), 441 + i);
            chk("man_step_y", int'(posy), 362);
        end
        for (int i = 0; i < 437; i++) frame(0, 1, 0, 1, 0, $urandom_range(1, 3));
        chk("reach_xmax", int'(posx), 880);
        frame(0, 1, 0, 1, 0, 1);
        chk("wrap_plus", int'(posx), 0);
        frame(0, 1, 0, 0, 0, 2);
        chk("wrap_minus", int'(posx), 880);
        for (int i = 0; i < 4; i++) frame(0, 1, 0, 0, 0, 1);
        chk("preset_876", int'(posx), 876);

        frame(1, 0, 0, 0, 0, 1);
        chk("auto_878", int'(posx), 878);
        frame(1, 0, 0, 0, 0, 1);
        chk("auto_880", int'(posx), 880);
        frame(1, 0, 0, 0, 0, 1);
        chk("auto_back_878", int'(posx), 878);
        chk("auto_mode", int'(mode), 1);

        frame(1, 0, 1, 0, 0, 1);
        chk("hold_mode", int'(mode), 2);
        chk("hold_posy", int'(posy), 367);
        for (int i = 0; i < 59; i++) frame(1, 0, 0, 0, 0, 1);
        chk("hold_59", int'(mode), 2);
        frame(1, 0, 0, 0, 0, 1);
        chk("hold_exit_mode", int'(mode), 1);
        chk("hold_exit_nomove", int'(posx), 878);
        frame(1, 0, 0, 0, 0, 1);
        chk("resume_bounce", int'(posx), 876);

        frame(1, 1, 0, 1, 0, 1);
        chk("hold_again", int'(mode), 2);
        frame(0, 1, 0, 1, 0, 1);
        chk("drop_auto_mode", int'(mode), 0);
        chk("drop_auto_move", int'(posx), 878);

        frame(1, 0, 0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_rst_posx", int'(posx), 440);
        chk("async_rst_posy", int'(posy), 362);
        chk("async_rst_mode", int'(mode), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        auto_en = 1'b1; key_x_n = 1'b1; key_y_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 VGA_VS = 1'b1;
        model_tick(1, 0, 0, 0, 0);
        q.push_back('{x: m_x, y: m_y, md: m_mode});
        ticks = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
        end
        chk("vs_held_ticks", ticks, 1);
        #1 VGA_VS = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            frame($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  1'($urandom), 1'($urandom), $urandom_range(1, 4));
        end

        repeat (10) @(posedge clk);
        chk("pending_ticks", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
